// File: rtl/icache_dataram_rd_ctrl.sv
// icache_dataram_rd_ctrl
// Data-array stage behind the icache tag stage. Tag-hit reads and linefill
// writes share one port of a 2-way data RAM that has a 1-cycle read latency.
// Read data is queued in an output FIFO for the fetch consumer. The block
// raises stall toward the tag stage early enough that no hit read is lost.

module icache_dataram_rd_ctrl #(
    parameter int INDEX_WIDTH = 7,
    parameter int LINE_WIDTH  = 256,
    parameter int TXNID_WIDTH = 5,
    parameter int FIFO_DEPTH  = 4      // power of 2, at least 3
) (
    input  logic                   clk,
    input  logic                   rst_n,

    // Tag-hit read requests (no back-pressure on this interface)
    input  logic                   rd_vld,
    input  logic [INDEX_WIDTH-1:0] rd_index,
    input  logic                   rd_way,
    input  logic [TXNID_WIDTH-1:0] rd_txnid,

    // Linefill write requests
    input  logic                   wr_vld,
    output logic                   wr_rdy,
    input  logic [INDEX_WIDTH-1:0] wr_index,
    input  logic                   wr_way,
    input  logic [LINE_WIDTH-1:0]  wr_data,

    // Response stream toward fetch
    output logic                   resp_vld,
    input  logic                   resp_rdy,
    output logic [TXNID_WIDTH-1:0] resp_txnid,
    output logic [LINE_WIDTH-1:0]  resp_data,

    // Flow control and status
    output logic                   stall,
    output logic                   ovf_err
);

    localparam int LINES     = 1 << INDEX_WIDTH;
    localparam int RAM_WORDS = 2 * LINES;
    localparam int ADDR_W    = INDEX_WIDTH + 1;
    localparam int PTR_W     = $clog2(FIFO_DEPTH);
    localparam int CNT_W     = PTR_W + 1;
    localparam int OCC_W     = CNT_W + 1;

    // ------------------------------------------------------------------
    // Data RAM: both ways in one array, addressed by {way, index}
    // ------------------------------------------------------------------
    logic [LINE_WIDTH-1:0]  r_ram [RAM_WORDS];

    logic [ADDR_W-1:0]      w_rd_addr;
    logic [ADDR_W-1:0]      w_wr_addr;
    logic                   w_wr_fire;

    // Stage s1: read data and its transaction id, one cycle after the request
    logic                   r_s1_vld;
    logic [TXNID_WIDTH-1:0] r_s1_txnid;
    logic [LINE_WIDTH-1:0]  r_s1_data;

    // Output FIFO
    logic [LINE_WIDTH-1:0]  r_fifo_data  [FIFO_DEPTH];
    logic [TXNID_WIDTH-1:0] r_fifo_txnid [FIFO_DEPTH];
    logic [PTR_W-1:0]       r_wr_ptr;
    logic [PTR_W-1:0]       r_rd_ptr;
    logic [CNT_W-1:0]       r_count;
    logic                   r_ovf_err;

    logic                   w_push;
    logic                   w_pop;
    logic                   w_full;
    logic                   w_push_ok;
    logic                   w_ovf;

    // Stall terms
    logic [OCC_W-1:0]       w_occ;
    logic                   w_occ_hi;
    logic                   w_wr_blocked;

    // ------------------------------------------------------------------
    // Arbitration: reads always win the single RAM port
    // ------------------------------------------------------------------
    assign wr_rdy    = ~rd_vld;
    assign w_wr_fire = wr_vld & ~rd_vld;
    assign w_rd_addr = {rd_way, rd_index};
    assign w_wr_addr = {wr_way, wr_index};

    // RAM write on linefill handshake; registered read feeds stage s1
    always_ff @(posedge clk) begin
        if (w_wr_fire) begin
            r_ram[w_wr_addr] <= wr_data;
        end
        if (rd_vld) begin
            r_s1_data  <= r_ram[w_rd_addr];
            r_s1_txnid <= rd_txnid;
        end
    end

    // Stage s1 valid: the only control state of the read pipeline
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_s1_vld <= 1'b0;
        end else begin
            r_s1_vld <= rd_vld;
        end
    end

    // ------------------------------------------------------------------
    // Output FIFO. A push into a full FIFO is accepted only when the head
    // leaves in the same cycle; otherwise the entry is dropped and flagged.
    // ------------------------------------------------------------------
    assign w_push    = r_s1_vld;
    assign resp_vld  = (r_count != '0);
    assign w_pop     = resp_vld & resp_rdy;
    assign w_full    = (r_count == CNT_W'(FIFO_DEPTH));
    assign w_push_ok = w_push & (~w_full | w_pop);
    assign w_ovf     = w_push & w_full & ~w_pop;

    assign resp_txnid = r_fifo_txnid[r_rd_ptr];
    assign resp_data  = r_fifo_data[r_rd_ptr];
    assign ovf_err    = r_ovf_err;

    // FIFO storage write; with a full FIFO and a pop the write slot is the
    // one being vacated, so the head is consumed before it is overwritten
    always_ff @(posedge clk) begin
        if (w_push_ok) begin
            r_fifo_data[r_wr_ptr]  <= r_s1_data;
            r_fifo_txnid[r_wr_ptr] <= r_s1_txnid;
        end
    end

    // FIFO pointers, occupancy and the sticky overflow flag
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_wr_ptr  <= '0;
            r_rd_ptr  <= '0;
            r_count   <= '0;
            r_ovf_err <= 1'b0;
        end else begin
            if (w_push_ok) begin
                r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            end
            if (w_push_ok && !w_pop) begin
                r_count <= r_count + CNT_W'(1);
            end else if (!w_push_ok && w_pop) begin
                r_count <= r_count - CNT_W'(1);
            end
            if (w_ovf) begin
                r_ovf_err <= 1'b1;
            end
        end
    end

    // ------------------------------------------------------------------
    // Stall toward the tag stage.
    // Occupancy counts entries in the FIFO, the read in s1 and the read
    // being issued now. Stalling at FIFO_DEPTH-1 keeps one slot free for a
    // read the tag stage launches before it reacts to stall. A refused
    // linefill also stalls, so reads pause and the write gets the port.
    // ------------------------------------------------------------------
    assign w_occ        = OCC_W'(r_count) + OCC_W'(r_s1_vld) + OCC_W'(rd_vld);
    assign w_occ_hi     = (w_occ >= OCC_W'(FIFO_DEPTH - 1));
    assign w_wr_blocked = wr_vld & ~wr_rdy;
    assign stall        = w_wr_blocked | w_occ_hi;

endmodule

// File: tb/tb_icache_dataram_rd_ctrl.sv
// Bench for icache_dataram_rd_ctrl: directed scenarios followed by random
// traffic, all outputs compared every cycle against a queue-based model.

module tb_icache_dataram_rd_ctrl;

    localparam int IW = 7;
    localparam int LW = 256;
    localparam int TW = 5;
    localparam int D  = 4;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          rd_vld;
    logic [IW-1:0] rd_index;
    logic          rd_way;
    logic [TW-1:0] rd_txnid;
    logic          wr_vld;
    logic          wr_rdy;
    logic [IW-1:0] wr_index;
    logic          wr_way;
    logic [LW-1:0] wr_data;
    logic          resp_vld;
    logic          resp_rdy;
    logic [TW-1:0] resp_txnid;
    logic [LW-1:0] resp_data;
    logic          stall;
    logic          ovf_err;

    always #5 clk = ~clk;

    icache_dataram_rd_ctrl #(
        .INDEX_WIDTH (IW),
        .LINE_WIDTH  (LW),
        .TXNID_WIDTH (TW),
        .FIFO_DEPTH  (D)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .rd_vld     (rd_vld),
        .rd_index   (rd_index),
        .rd_way     (rd_way),
        .rd_txnid   (rd_txnid),
        .wr_vld     (wr_vld),
        .wr_rdy     (wr_rdy),
        .wr_index   (wr_index),
        .wr_way     (wr_way),
        .wr_data    (wr_data),
        .resp_vld   (resp_vld),
        .resp_rdy   (resp_rdy),
        .resp_txnid (resp_txnid),
        .resp_data  (resp_data),
        .stall      (stall),
        .ovf_err    (ovf_err)
    );

    // Reference model: line contents per way, one in-flight read, FIFO queue
    typedef struct packed {
        logic [TW-1:0] txn;
        logic [LW-1:0] data;
    } ent_t;

    logic [LW-1:0] m_ram [2][1 << IW];
    ent_t          m_q [$];
    bit            m_s1;
    ent_t          m_s1e;
    bit            m_ovf;

    int n_chk  = 0;
    int n_pass = 0;

    task automatic chk(input string tag, input logic [LW-1:0] got, input logic [LW-1:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    endtask

    // Stall rule: refused linefill, or FIFO + pending + new read reaches D-1
    function automatic bit exp_stall();
        return (wr_vld && rd_vld) || ((m_q.size() + int'(m_s1) + int'(rd_vld)) >= D - 1);
    endfunction

    // One clock: compare at negedge, advance model at posedge
    task automatic cycle();
        bit popped;
        @(negedge clk);
        if (rst_n) begin
            chk("stall", stall, exp_stall());
            chk("wr_rdy", wr_rdy, !rd_vld);
            chk("resp_vld", resp_vld, m_q.size() != 0);
            chk("ovf_err", ovf_err, m_ovf);
            if (m_q.size() != 0) begin
                chk("resp_txnid", resp_txnid, m_q[0].txn);
                chk("resp_data", resp_data, m_q[0].data);
            end
        end
        @(posedge clk);
        if (!rst_n) begin
            m_q.delete();
            m_s1  = 1'b0;
            m_ovf = 1'b0;
        end else begin
            popped = (m_q.size() != 0) && resp_rdy;
            if (popped) void'(m_q.pop_front());
            if (m_s1) begin
                if (m_q.size() >= D) m_ovf = 1'b1;
                else m_q.push_back(m_s1e);
            end
            if (rd_vld) m_s1e = '{txn: rd_txnid, data: m_ram[rd_way][rd_index]};
            m_s1 = rd_vld;
        end
        if (wr_vld && !rd_vld) m_ram[wr_way][wr_index] = wr_data;
        #1;
    endtask

    task automatic set_rd(input int idx, input bit way, input int txn);
        rd_vld   = 1'b1;
        rd_index = IW'(idx);
        rd_way   = way;
        rd_txnid = TW'(txn);
    endtask

    logic [LW-1:0] pat_a5;
    logic [LW-1:0] pat_5a;
    bit            prev_stall;

    initial begin
        pat_a5   = {32{8'hA5}};
        pat_5a   = {32{8'h5A}};
        rst_n    = 1'b0;
        rd_vld   = 1'b0;
        rd_index = '0;
        rd_way   = 1'b0;
        rd_txnid = '0;
        wr_vld   = 1'b0;
        wr_index = '0;
        wr_way   = 1'b0;
        wr_data  = '0;
        resp_rdy = 1'b0;
        m_s1     = 1'b0;
        m_ovf    = 1'b0;

        repeat (2) cycle();
        rst_n = 1'b1;
        #1;
        chk("rst_resp_vld", resp_vld, 0);
        chk("rst_stall", stall, 0);
        chk("rst_wr_rdy", wr_rdy, 1);
        chk("rst_ovf", ovf_err, 0);

        // Linefill way1 idx5, then read it back
        wr_vld = 1'b1; wr_way = 1'b1; wr_index = 7'h05; wr_data = pat_a5;
        cycle();
        wr_vld = 1'b0;
        set_rd(5, 1'b1, 3);
        cycle();
        rd_vld = 1'b0;
        cycle();
        chk("t2_resp_vld", resp_vld, 1);
        chk("t2_resp_txnid", resp_txnid, 3);
        chk("t2_resp_data", resp_data, pat_a5);
        resp_rdy = 1'b1;
        cycle();

        // Read and linefill in the same cycle: write refused, then completes
        wr_vld = 1'b1; wr_way = 1'b0; wr_index = 7'h09; wr_data = pat_5a;
        set_rd(5, 1'b1, 7);
        #1;
        chk("collide_wr_rdy", wr_rdy, 0);
        chk("collide_stall", stall, 1);
        cycle();
        rd_vld = 1'b0;
        cycle();
        wr_vld = 1'b0;
        set_rd(9, 1'b0, 8);
        cycle();
        rd_vld = 1'b0;
        repeat (3) cycle();

        // Back-to-back reads into a stopped consumer, then full push+pop
        resp_rdy = 1'b0;
        for (int t = 0; t < 5; t++) begin
            set_rd(5, 1'b1, t);
            cycle();
        end
        rd_vld = 1'b0;
        resp_rdy = 1'b1;
        cycle();
        chk("fullpp_ovf", ovf_err, 0);
        chk("fullpp_head", resp_txnid, 1);
        repeat (5) cycle();

        // Forced overflow: read issued with four entries queued and s1 busy
        resp_rdy = 1'b0;
        for (int t = 0; t < 5; t++) begin
            set_rd(9, 1'b0, 10 + t);
            cycle();
        end
        rd_vld = 1'b0;
        repeat (2) cycle();
        chk("ovf_set", ovf_err, 1);
        resp_rdy = 1'b1;
        repeat (6) cycle();
        chk("ovf_sticky", ovf_err, 1);

        // Reset with two FIFO entries and s1 occupied
        resp_rdy = 1'b0;
        for (int t = 0; t < 3; t++) begin
            set_rd(5, 1'b1, 20 + t);
            cycle();
        end
        rd_vld = 1'b0;
        rst_n  = 1'b0;
        cycle();
        rst_n = 1'b1;
        #1;
        chk("midrst_resp_vld", resp_vld, 0);
        chk("midrst_stall", stall, 0);
        chk("midrst_ovf", ovf_err, 0);
        set_rd(5, 1'b1, 9);
        cycle();
        rd_vld = 1'b0;
        cycle();
        chk("midrst_ram_kept", resp_data, pat_a5);
        resp_rdy = 1'b1;
        repeat (2) cycle();

        // Prefill lines 0..15 of both ways for random traffic
        for (int i = 0; i < 32; i++) begin
            wr_vld   = 1'b1;
            wr_way   = i[0];
            wr_index = IW'(i >> 1);
            wr_data  = {8{$urandom()}};
            cycle();
        end
        wr_vld = 1'b0;

        // Random traffic; tag stage reacts to stall one cycle late
        prev_stall = 1'b0;
        for (int i = 0; i < 3000; i++) begin
            rd_vld   = !prev_stall && ($urandom_range(0, 99) < 60);
            rd_index = IW'($urandom_range(0, 15));
            rd_way   = 1'($urandom_range(0, 1));
            rd_txnid = TW'($urandom());
            wr_vld   = ($urandom_range(0, 99) < 30);
            wr_index = IW'($urandom_range(0, 15));
            wr_way   = 1'($urandom_range(0, 1));
            wr_data  = {8{$urandom()}};
            resp_rdy = ($urandom_range(0, 99) < 50);
            prev_stall = exp_stall();
            cycle();
        end
        rd_vld = 1'b0;
        wr_vld = 1'b0;
        resp_rdy = 1'b1;
        repeat (8) cycle();
        chk("rand_no_ovf", ovf_err, 0);
        chk("rand_drained", resp_vld, 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/icache_dataram_rd_ctrl.md
Name: icache_dataram_rd_ctrl

Overview:
- Data-array stage directly downstream of the icache tag stage.
- Consumes tag-hit read requests (index/way/txnid) and linefill write requests, and arbitrates them onto a 2-way data RAM with 1-cycle read latency.
- Buffers read data in an output FIFO toward the fetch consumer.
- Drives `stall` back to the tag stage so that no hit read is ever dropped.

Parameters:
- INDEX_WIDTH, 7, set index width; each way holds 2**INDEX_WIDTH lines.
- LINE_WIDTH, 256, cache line width in bits.
- TXNID_WIDTH, 5, transaction id width.
- FIFO_DEPTH, 4, output FIFO entries; minimum 3, power of 2.

Ports:
- clk  in  1  clock; all logic on rising edge.
- rst_n  in  1  synchronous active-low reset.
- rd_vld  in  1  tag-hit read request; has no ready, must always be accepted.
- rd_index  in  INDEX_WIDTH  set index of read.
- rd_way  in  1  way of read (0/1).
- rd_txnid  in  TXNID_WIDTH  read txn id.
- wr_vld  in  1  linefill write request.
- wr_rdy  out  1  write accepted this cycle when wr_vld & wr_rdy.
- wr_index  in  INDEX_WIDTH  linefill set index.
- wr_way  in  1  linefill destination way.
- wr_data  in  LINE_WIDTH  linefill line data.
- resp_vld  out  1  output FIFO head valid.
- resp_rdy  in  1  consumer ready.
- resp_txnid  out  TXNID_WIDTH  head txn id.
- resp_data  out  LINE_WIDTH  head line data.
- stall  out  1  to tag stage: block new tag requests.
- ovf_err  out  1  sticky: read data arrived with FIFO full.

Behaviour:
- Reset (rst_n=0 at posedge):
  - FIFO empties; s1_vld=0; ovf_err=0.
  - resp_vld=0, stall=0, wr_rdy=1 (combinational from rd_vld=0).
  - RAM contents are not reset.
  - Reset mid-operation discards all in-flight reads and FIFO entries.
- Arbitration, one RAM op per cycle:
  - Read has priority.
  - wr_rdy = ~rd_vld.
  - A write handshake writes wr_data into way wr_way, line wr_index, at that edge.
- Read pipeline:
  - Cycle T: rd_vld; RAM is read and txnid is captured into stage s1 (s1_vld<=1).
  - Cycle T+1: RAM data and s1 txnid are pushed into the FIFO.
  - resp_vld is high from T+2 at the earliest; there is no FIFO bypass.
- Write then read, same index/way:
  - Write at T, read at T+1 returns the new data.
  - Read and write in the same cycle cannot collide, because the write is refused.
- FIFO:
  - Push when s1_vld; pop when resp_vld & resp_rdy.
  - Simultaneous push and pop on a full FIFO is legal; count is unchanged.
  - Pointers are log2(FIFO_DEPTH) bits and wrap naturally.
  - Count is log2(FIFO_DEPTH)+1 bits.
  - Output order is arrival order.
- Overflow:
  - Push when count==FIFO_DEPTH and no pop: data is dropped and ovf_err is set.
  - ovf_err is cleared only by reset.
- Stall (combinational): stall = (wr_vld & ~wr_rdy) | (count + s1_vld + rd_vld >= FIFO_DEPTH-1).
  - This reserves room for one further read already issued by the tag stage before it sees stall.
  - It also gives a blocked linefill a free slot within 2 cycles.
- Read latency rule: a read accepted while stall=0 never overflows, under any resp_rdy pattern.
- stall and wr_rdy have no reset-dependent state beyond count/s1_vld.

Test Plan:
- Reset, then linefill way1 idx 0x05 data 0xA5.. (wr_vld=1, rd_vld=0) -> wr_rdy=1; read idx 5 way 1 txnid 3 -> resp_vld at T+2, resp_txnid=3, resp_data=0xA5...
- wr_vld and rd_vld both high, same cycle -> wr_rdy=0, read proceeds; stall=1; write completes the next cycle rd_vld=0; that line readable at T+1 after write.
- resp_rdy=0, back-to-back reads txnid 0..3 with FIFO_DEPTH=4 -> stall rises once count+s1+rd reaches 3; 4 entries held, ovf_err=0; then resp_rdy=1 drains txnids 0,1,2,3 in order, one per cycle.
- Full FIFO with simultaneous push and pop -> count stays 4, no ovf_err, order preserved.
- Force a read with count==4, resp_rdy=0 -> ovf_err=1 on push edge, stays 1 until rst_n=0.
- Assert rst_n=0 with 2 FIFO entries and s1_vld=1 -> next cycle resp_vld=0, stall=0, ovf_err=0; RAM data written earlier still reads back.
